vecmat_add_sched: RTL and testbench

VECMAT_ADD_SCHED -- requirements
Module: vecmat_add_sched

---
 rtl/vecmat_add_sched.sv | 115 +++++++++++
 tb/tb_vecmat_add_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vecmat_add_sched.sv
// Dot-product scheduler: feeds 512-bit product chunks to an external adder tree
// and accumulates the tree results into a single 16-bit job result.
module vecmat_add_sched #(
  parameter int ARRAYSIZE = 512,
  parameter int TREE_LAT  = 2,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_chunks,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ARRAYSIZE-1:0] in_data,
  output logic [ARRAYSIZE-1:0] tree_in,
  input  logic [15:0]          tree_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_r, state_nxt_s;
  logic [CNT_W-1:0]     n_r, issue_cnt_r, acc_cnt_r;
  logic [15:0]          acc_r;
  logic [TREE_LAT:0]    tag_r;
  logic [ARRAYSIZE-1:0] tree_in_r;
  logic                 done_r;
  logic                 accept_s, launch_s, last_issue_s, last_acc_s, handoff_s;

  assign accept_s     = in_valid && (state_r == FEED);
  assign launch_s     = (state_r == IDLE) && start && (num_chunks != {CNT_W{1'b0}});
  assign last_issue_s = accept_s && ((issue_cnt_r + CNT_ONE) == n_r);
  // The tag leaving the last stage marks the cycle tree_sum belongs to a real chunk.
  assign last_acc_s   = tag_r[TREE_LAT] && ((acc_cnt_r + CNT_ONE) == n_r);
  assign handoff_s    = (state_r == OUT) && out_ready;

  // Next-state decode; clear overrides everything, including a concurrent start.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (launch_s)     state_nxt_s = FEED;  else state_nxt_s = IDLE;
        FEED:    if (last_issue_s) state_nxt_s = DRAIN; else state_nxt_s = FEED;
        DRAIN:   if (last_acc_s)   state_nxt_s = OUT;   else state_nxt_s = DRAIN;
        OUT:     if (handoff_s)    state_nxt_s = IDLE;  else state_nxt_s = OUT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath: operand issue, tag pipeline, accumulation and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tree_in_r   <= {ARRAYSIZE{1'b0}};
      tag_r       <= {(TREE_LAT+1){1'b0}};
      acc_r       <= 16'd0;
      n_r         <= {CNT_W{1'b0}};
      issue_cnt_r <= {CNT_W{1'b0}};
      acc_cnt_r   <= {CNT_W{1'b0}};
      done_r      <= 1'b0;
    end else if (clear) begin
      tree_in_r   <= {ARRAYSIZE{1'b0}};
      tag_r       <= {(TREE_LAT+1){1'b0}};
      acc_r       <= 16'd0;
      n_r         <= {CNT_W{1'b0}};
      issue_cnt_r <= {CNT_W{1'b0}};
      acc_cnt_r   <= {CNT_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      tree_in_r <= accept_s ? in_data : {ARRAYSIZE{1'b0}};
      tag_r     <= {tag_r[TREE_LAT-1:0], accept_s};
      done_r    <= handoff_s;
      if (launch_s) begin
        n_r         <= num_chunks;
        issue_cnt_r <= {CNT_W{1'b0}};
        acc_cnt_r   <= {CNT_W{1'b0}};
        acc_r       <= 16'd0;
      end else begin
        if (accept_s) issue_cnt_r <= issue_cnt_r + CNT_ONE;
        if (tag_r[TREE_LAT]) begin
          acc_r     <= acc_r + tree_sum;
          acc_cnt_r <= acc_cnt_r + CNT_ONE;
        end
      end
    end
  end

  assign tree_in   = tree_in_r;
  assign in_ready  = (state_r == FEED);
  assign out_valid = (state_r == OUT);
  assign out_data  = (state_r == OUT) ? acc_r : 16'd0;
  assign busy      = (state_r != IDLE);
  assign done      = done_r;

endmodule

// File: tb/tb_vecmat_add_sched.sv
// Randomized self-checking bench for vecmat_add_sched with a 2-stage adder tree
// and a sum-of-all-lanes reference model.
module tb_vecmat_add_sched;
  localparam int AS = 512;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset, clear, start, in_valid, out_ready;
  logic [CW-1:0] num_chunks;
  logic [AS-1:0] in_data;
  logic [AS-1:0] tree_in;
  logic [15:0]   tree_sum, out_data;
  logic          in_ready, out_valid, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [AS-1:0] chunks [0:63];
  int gaps [0:63];

  vecmat_add_sched #(.ARRAYSIZE(AS), .TREE_LAT(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .num_chunks(num_chunks),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .tree_in(tree_in),
    .tree_sum(tree_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage adder tree: half sums, then the total.
  logic [15:0] half0_r, half1_r;
  function automatic logic [15:0] half_sum(input logic [AS-1:0] d, input int lo);
    logic [15:0] s;
    s = 16'd0;
    for (int k = lo; k < lo + 16; k++) s = s + d[16*k +: 16];
    return s;
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      half0_r <= 16'd0; half1_r <= 16'd0; tree_sum <= 16'd0;
    end else begin
      half0_r  <= half_sum(tree_in, 0);
      half1_r  <= half_sum(tree_in, 16);
      tree_sum <= half0_r + half1_r;
    end
  end

  function automatic logic [AS-1:0] fill(input logic [15:0] v);
    logic [AS-1:0] d;
    for (int k = 0; k < 32; k++) d[16*k +: 16] = v;
    return d;
  endfunction

  // Reference: sum of every lane of every chunk, truncated to 16 bits.
  function automatic logic [15:0] model_sum(input int n);
    longint s;
    logic [AS-1:0] c;
    s = 0;
    for (int i = 0; i < n; i++) begin
      c = chunks[i];
      for (int k = 0; k < 32; k++) s += c[16*k +: 16];
    end
    return s[15:0];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic feed_chunks(input int first, input int cnt, output int last_acc);
    last_acc = -1;
    for (int i = first; i < first + cnt; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < gaps[i]; g++) tick();
      in_valid = 1'b1;
      in_data  = chunks[i];
      for (int k = 0; k < 10 && !in_ready; k++) tick();
      tick();
      last_acc = cyc;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic start_job(input int n);
    start = 1'b1; num_chunks = n[CW-1:0];
    tick();
    start = 1'b0;
  endtask

  task automatic wait_out(output int oc);
    for (int k = 0; k < 30 && !out_valid; k++) tick();
    oc = out_valid ? cyc : -1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    num_chunks = '0; in_data = '0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (tree_in !== '0)     begin errors++; $display("FAIL reset_tree_in nonzero"); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int la, oc;
    chunks[0] = fill(16'h0001); gaps[0] = 0;
    start_job(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    feed_chunks(0, 1, la);
    wait_out(oc);
    checks++; if (oc - la !== 3) begin errors++; $display("FAIL single_latency got %0d exp 3", oc - la); end
    checks++; if (out_data !== 16'h0020) begin errors++; $display("FAIL single_data got %h exp 0020", out_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early got %b exp 0", done); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done); end
    checks++; if (out_data !== 16'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_after got %h/%b exp 0000/0", out_data, out_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", done); end
  endtask

  task automatic test_gaps();
    int la, oc;
    for (int i = 0; i < 4; i++) chunks[i] = fill(16'h0100);
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 1; gaps[3] = 0;
    start_job(4);
    feed_chunks(0, 4, la);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gaps_in_ready got %b exp 0", in_ready); end
    wait_out(oc);
    checks++; if (oc - la !== 3) begin errors++; $display("FAIL gaps_latency got %0d exp 3", oc - la); end
    checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL gaps_data got %h exp 8000", out_data); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int la, oc;
    chunks[0] = fill(16'h0480); chunks[1] = fill(16'h0480); gaps[0] = 0; gaps[1] = 1;
    start_job(2);
    feed_chunks(0, 2, la);
    wait_out(oc);
    checks++; if (out_data !== 16'h2000) begin errors++; $display("FAIL wrap_data got %h exp 2000", out_data); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int la, oc;
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      chunks[i] = {16{$urandom()}}; gaps[i] = $urandom_range(0, 2);
    end
    exp = model_sum(3);
    start_job(3);
    feed_chunks(0, 3, la);
    wait_out(oc);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin start = 1'b1; num_chunks = 6'd2; end
      tick();
      start = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0)
        begin errors++; $display("FAIL hold_c%0d got v=%b d=%h r=%b exp 1/%h/0", c, out_valid, out_data, in_ready, exp); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done got %b exp 1", done); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_start_ignored busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_midjob();
    int la, oc;
    for (int i = 0; i < 4; i++) begin chunks[i] = fill(16'h0100); gaps[i] = 0; end
    start_job(4);
    feed_chunks(0, 2, la);
    reset = 1'b0; #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 || done !== 1'b0 || tree_in !== '0)
      begin errors++; $display("FAIL midreset_outputs got busy=%b rdy=%b v=%b d=%h done=%b", busy, in_ready, out_valid, out_data, done); end
    tick(); reset = 1'b1; tick();
    chunks[0] = fill(16'h0002); gaps[0] = 1;
    start_job(1);
    feed_chunks(0, 1, la);
    wait_out(oc);
    checks++; if (out_data !== 16'h0040) begin errors++; $display("FAIL midreset_job got %h exp 0040", out_data); end
    checks++; if (oc - la !== 3) begin errors++; $display("FAIL midreset_latency got %0d exp 3", oc - la); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_zero_and_clear();
    int la, seen;
    start_job(0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin if (busy || out_valid) seen++; tick(); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL zero_n got %0d busy cycles exp 0", seen); end
    start = 1'b1; clear = 1'b1; num_chunks = 6'd1; tick(); start = 1'b0; clear = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_clear busy got %b exp 0", busy); end
    chunks[0] = fill(16'h0011); chunks[1] = fill(16'h0011); gaps[0] = 0; gaps[1] = 0;
    start_job(2);
    feed_chunks(0, 2, la);
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL drain_clear got busy=%b done=%b exp 0/0", busy, done); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin if (out_valid || busy) seen++; tick(); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL drain_clear_result got %0d cycles exp 0", seen); end
  endtask

  task automatic test_random();
    int n, la, oc;
    logic [15:0] exp;
    logic [AS-1:0] c;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 32; k++) c[16*k +: 16] = $urandom();
        chunks[i] = c; gaps[i] = $urandom_range(0, 3);
      end
      exp = model_sum(n);
      start_job(n);
      feed_chunks(0, n, la);
      wait_out(oc);
      checks++; if (out_data !== exp) begin errors++; $display("FAIL rand%0d_data got %h exp %h", j, out_data, exp); end
      checks++; if (oc - la !== 3) begin errors++; $display("FAIL rand%0d_latency got %0d exp 3", j, oc - la); end
      for (int d = $urandom_range(0, 3); d > 0; d--) tick();
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rand%0d_handoff got done=%b busy=%b exp 1/0", j, done, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_wrap();
    test_backpressure();
    test_reset_midjob();
    test_zero_and_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
